// File: rtl/rv32_fetch_queue.sv
// RV32 instruction fetch queue: a single-outstanding-request fetch engine feeding
// a DEPTH-entry {pc, instr} FIFO toward decode, with redirect flush and kill handling.
module rv32_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           mem_req_valid,
    output logic [31:0]                    mem_req_addr,
    input  logic                           mem_req_done,
    input  logic [31:0]                    mem_rdata,
    output logic                           out_valid,
    output logic [31:0]                    out_pc,
    output logic [31:0]                    out_instr,
    input  logic                           out_ready,
    input  logic                           redirect,
    input  logic [31:0]                    redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     target_q;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            out_valid_q;
    logic            mem_req_valid_q;
    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic            push, pop, room;
    logic [31:0]     redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        push    = (state_q == BUSY) && mem_req_done && !redirect;
        pop     = out_valid_q && out_ready && !redirect;
        count_d = count_q + CW'(push) - CW'(pop);
        // The outstanding request already owns a slot, so only issue when one is left after it lands.
        room    = (count_d < CW'(DEPTH));
    end

    // NOTE: the storage array carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RESET_PC;
            target_q        <= RESET_PC;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            mem_req_valid_q <= 1'b0;
        end else if (redirect) begin
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            mem_req_valid_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    fetch_pc_q <= redirect_tgt;
                    state_q    <= BUSY;
                end
                BUSY: begin
                    if (mem_req_done) begin
                        fetch_pc_q <= redirect_tgt;
                        state_q    <= BUSY;
                    end else begin
                        // Keep presenting the killed address until memory completes it.
                        target_q <= redirect_tgt;
                        state_q  <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_req_done) begin
                        fetch_pc_q <= redirect_tgt;
                        state_q    <= BUSY;
                    end else begin
                        target_q <= redirect_tgt;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end else begin
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (room) begin
                        state_q         <= BUSY;
                        mem_req_valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_req_done) begin
                        fetch_pc_q      <= fetch_pc_q + 32'd4;
                        state_q         <= room ? BUSY : IDLE;
                        mem_req_valid_q <= room;
                    end
                end
                DISCARD: begin
                    if (mem_req_done) begin
                        fetch_pc_q <= target_q;
                        state_q    <= BUSY;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = fetch_pc_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = pc_mem[rd_ptr_q];
    assign out_instr     = instr_mem[rd_ptr_q];
    assign count         = count_q;

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Directed self-checking bench for rv32_fetch_queue: streaming, backpressure,
// redirect with and without done, double redirect, and reset mid-operation.
module tb_rv32_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_done;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int checks;
    int errors;

    rv32_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_done  (mem_req_done),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_ready     (out_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .count         (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs just after a falling edge, then advance to the next falling edge.
    task automatic cycle(input logic done, input logic ready, input logic redir, input logic [31:0] rpc);
        mem_req_done = done;
        mem_rdata    = instr_of(mem_req_addr);
        out_ready    = ready;
        redirect     = redir;
        redirect_pc  = rpc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        mem_req_done = 1'b0;
        mem_rdata    = 32'h0;
        out_ready    = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        @(negedge clk);

        // Reset state, with done asserted during reset to show it is ignored.
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b0;

        // Streaming: one entry per cycle, consecutive PCs, no bubbles.
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("first_req_valid", 32'(mem_req_valid), 32'd1);
        check("first_req_addr", mem_req_addr, RESET_PC);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            check("stream_out_valid", 32'(out_valid), 32'd1);
            check("stream_out_pc", out_pc, 32'(4 * (k - 1)));
            check("stream_out_instr", out_instr, instr_of(32'(4 * (k - 1))));
            check("stream_count", 32'(count), 32'd1);
            check("stream_addr", mem_req_addr, 32'(4 * k));
        end

        // Backpressure: fill to DEPTH, requests stop, then resume at 0x10.
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            check("bp_fill_count", 32'(count), 32'(k));
        end
        check("bp_full_req_valid", 32'(mem_req_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("bp_hold_req_valid", 32'(mem_req_valid), 32'd0);
        check("bp_hold_count", 32'(count), 32'd4);
        check("bp_hold_head", out_pc, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("bp_resume_req_valid", 32'(mem_req_valid), 32'd1);
        check("bp_resume_addr", mem_req_addr, 32'h10);
        check("bp_resume_count", 32'(count), 32'd3);
        check("bp_order_4", out_pc, 32'h4);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("bp_order_8", out_pc, 32'h8);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("bp_order_c", out_pc, 32'hC);
        check("bp_order_c_instr", out_instr, instr_of(32'hC));
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("bp_drained_count", 32'(count), 32'd0);
        check("bp_drained_valid", 32'(out_valid), 32'd0);
        check("bp_empty_pop_req_addr", mem_req_addr, 32'h10);
        // Pop with an empty queue is ignored.
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("bp_first_new_pc", out_pc, 32'h10);
        check("bp_first_new_count", 32'(count), 32'd1);

        // Redirect while done is withheld: DISCARD keeps the killed address.
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("kill_pre_addr", mem_req_addr, 32'h8);
        check("kill_pre_count", 32'(count), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 32'h103);
        check("kill_count", 32'(count), 32'd0);
        check("kill_out_valid", 32'(out_valid), 32'd0);
        check("kill_req_valid", 32'(mem_req_valid), 32'd1);
        check("kill_addr_hold0", mem_req_addr, 32'h8);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("kill_addr_hold1", mem_req_addr, 32'h8);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("kill_addr_hold2", mem_req_addr, 32'h8);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("kill_dropped_count", 32'(count), 32'd0);
        check("kill_next_addr", mem_req_addr, 32'h100);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("kill_first_pc", out_pc, 32'h100);
        check("kill_first_instr", out_instr, instr_of(32'h100));

        // Redirect coinciding with done: no push, no pop, restart at target.
        cycle(1'b1, 1'b1, 1'b1, 32'h40);
        check("rdone_count", 32'(count), 32'd0);
        check("rdone_out_valid", 32'(out_valid), 32'd0);
        check("rdone_req_valid", 32'(mem_req_valid), 32'd1);
        check("rdone_addr", mem_req_addr, 32'h40);

        // Double redirect during DISCARD: only the latest target is fetched.
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        check("dbl_addr_hold_a", mem_req_addr, 32'h40);
        cycle(1'b0, 1'b1, 1'b1, 32'h300);
        check("dbl_addr_hold_b", mem_req_addr, 32'h40);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("dbl_next_addr", mem_req_addr, 32'h300);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("dbl_first_pc", out_pc, 32'h300);

        // Reset mid-operation with two entries and a live request.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("mid_count_two", 32'(count), 32'd2);
        check("mid_req_valid", 32'(mem_req_valid), 32'd1);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("mid_restart_valid", 32'(mem_req_valid), 32'd1);
        check("mid_restart_addr", mem_req_addr, RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
